// File: rtl/bsg_gateway_seq_pkg.sv
// Shared types for the gateway link bring-up sequencer.
// Holds the state encoding, timed-state count and output decode.
package bsg_gateway_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_LINK_RST  = 3'd1,
    ST_LINK_WAIT = 3'd2,
    ST_LINK_EN   = 3'd3,
    ST_CHIP_RUN  = 3'd4,
    ST_RUN       = 3'd5
  } seq_state_e;

  localparam int unsigned NUM_TIMED_STATES = 5;

  typedef struct packed {
    logic link_reset;
    logic link_enable;
    logic chip_reset;
    logic node_en;
    logic done;
  } seq_out_t;

  // Illegal encodings decode like INIT so chip_reset stays asserted.
  function automatic seq_out_t seq_decode(input logic [2:0] s);
    seq_out_t o;
    o = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    unique case (s)
      3'd1:    o = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      3'd2:    o = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      3'd3:    o = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      3'd4:    o = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      3'd5:    o = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      default: o = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Step counter with synchronous clear (dominant) and increment.
// Ports: clk_i, reset_i (async high), clear_i, up_i, count_o.
module bsg_counter_clear_up #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;
  logic [width_p-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)   count_d = '0;
    else if (up_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_gateway_link_bringup_seq.sv
// Bring-up sequencer: link reset, link enable, chip reset release, node enable.
// Ports: clk_i, reset_i, restart_i, error_i -> link/chip/node controls, state, restarts.
module bsg_gateway_link_bringup_seq
  import bsg_gateway_seq_pkg::*;
#(
  parameter int delay_p               = 5000,
  parameter int counter_width_p       = 16,
  parameter int err_persist_p         = 1024,
  parameter int auto_restart_p        = 1,
  parameter int restart_count_width_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             restart_i,
  input  logic                             error_i,
  output logic                             link_reset_o,
  output logic                             link_enable_o,
  output logic                             chip_reset_o,
  output logic                             node_en_o,
  output logic                             done_o,
  output logic [2:0]                       state_o,
  output logic [restart_count_width_p-1:0] restart_count_o
);

  localparam int EW = $clog2(err_persist_p + 1);
  localparam logic [counter_width_p-1:0] DELAY =
    counter_width_p'(delay_p);
  localparam logic [EW-1:0] ERR_LAST = EW'(err_persist_p - 1);
  localparam logic [2:0] LAST_TIMED = 3'(NUM_TIMED_STATES - 1);

  seq_state_e state_q, state_d;
  logic [EW-1:0] err_q, err_d;
  logic [restart_count_width_p-1:0] rc_q, rc_d;
  logic restart_prev_q;
  seq_out_t out_q, out_d;

  logic [counter_width_p-1:0] step_cnt;
  logic timed, in_run, expire, auto_fire, restart_edge;
  logic cnt_clear;

  always_comb begin
    timed        = (3'(state_q) <= LAST_TIMED);
    in_run       = (state_q == ST_RUN);
    expire       = timed && (step_cnt == DELAY);
    auto_fire    = (auto_restart_p != 0) && in_run &&
                   error_i && (err_q == ERR_LAST);
    restart_edge = restart_i && !restart_prev_q;

    state_d = state_q;
    if (restart_i)    state_d = ST_INIT;
    else if (auto_fire) state_d = ST_INIT;
    else if (expire)  state_d = seq_state_e'(3'(state_q) + 3'd1);
    else if (!timed && !in_run) state_d = ST_INIT;

    err_d = '0;
    if ((auto_restart_p != 0) && in_run && error_i &&
        !restart_i && !auto_fire)
      err_d = err_q + 1'b1;

    // Held restart counts once; auto restart counts each firing.
    rc_d = rc_q;
    if ((restart_edge || (!restart_i && auto_fire)) && (rc_q != '1))
      rc_d = rc_q + 1'b1;

    cnt_clear = restart_i || auto_fire || expire || !timed;
    out_d     = seq_decode(3'(state_d));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_INIT;
      err_q          <= '0;
      rc_q           <= '0;
      restart_prev_q <= 1'b0;
      out_q          <= seq_decode(3'(ST_INIT));
    end else begin
      state_q        <= state_d;
      err_q          <= err_d;
      rc_q           <= rc_d;
      restart_prev_q <= restart_i;
      out_q          <= out_d;
    end
  end

  bsg_counter_clear_up #(
    .width_p(counter_width_p)
  ) u_step_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(cnt_clear),
    .up_i   (timed),
    .count_o(step_cnt)
  );

  assign link_reset_o    = out_q.link_reset;
  assign link_enable_o   = out_q.link_enable;
  assign chip_reset_o    = out_q.chip_reset;
  assign node_en_o       = out_q.node_en;
  assign done_o          = out_q.done;
  assign state_o         = 3'(state_q);
  assign restart_count_o = rc_q;

endmodule

// File: tb/tb_bsg_gateway_link_bringup_seq.sv
// Directed bench for the bring-up sequencer.
// Instance a: delay 4, auto restart after 8; instance b: delay 0, no auto, 2-bit count.
module tb_bsg_gateway_link_bringup_seq;

  logic clk;
  logic rst_a, rs_a, er_a;
  logic rst_b, rs_b, er_b;
  logic lr_a, le_a, cr_a, ne_a, dn_a;
  logic lr_b, le_b, cr_b, ne_b, dn_b;
  logic [2:0] st_a, st_b;
  logic [7:0] rc_a;
  logic [1:0] rc_b;

  int checks = 0;
  int errors = 0;

  bsg_gateway_link_bringup_seq #(
    .delay_p(4), .counter_width_p(16), .err_persist_p(8),
    .auto_restart_p(1), .restart_count_width_p(8)
  ) dut_a (
    .clk_i(clk), .reset_i(rst_a), .restart_i(rs_a), .error_i(er_a),
    .link_reset_o(lr_a), .link_enable_o(le_a), .chip_reset_o(cr_a),
    .node_en_o(ne_a), .done_o(dn_a), .state_o(st_a),
    .restart_count_o(rc_a)
  );

  bsg_gateway_link_bringup_seq #(
    .delay_p(0), .counter_width_p(4), .err_persist_p(8),
    .auto_restart_p(0), .restart_count_width_p(2)
  ) dut_b (
    .clk_i(clk), .reset_i(rst_b), .restart_i(rs_b), .error_i(er_b),
    .link_reset_o(lr_b), .link_enable_o(le_b), .chip_reset_o(cr_b),
    .node_en_o(ne_b), .done_o(dn_b), .state_o(st_b),
    .restart_count_o(rc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // link_reset/link_enable/chip_reset/node_en/done packed
  function automatic logic [31:0] outs_a();
    return {27'd0, lr_a, le_a, cr_a, ne_a, dn_a};
  endfunction

  function automatic logic [31:0] outs_b();
    return {27'd0, lr_b, le_b, cr_b, ne_b, dn_b};
  endfunction

  initial begin
    rst_a = 0; rs_a = 0; er_a = 0;
    rst_b = 0; rs_b = 0; er_b = 0;
    #1;
    rst_a = 1; rst_b = 1;
    #1;
    chk("a_reset_state", st_a, 0);
    chk("a_reset_outs", outs_a(), 32'b00100);
    chk("a_reset_rc", rc_a, 0);
    chk("b_reset_state", st_b, 0);
    chk("b_reset_outs", outs_b(), 32'b00100);

    @(negedge clk);
    rst_a = 0;
    step(4);
    chk("a_edge4_init", st_a, 0);
    chk("a_edge4_lr", lr_a, 0);
    step(1);
    chk("a_edge5_state", st_a, 1);
    chk("a_edge5_outs", outs_a(), 32'b10100);
    step(5);
    chk("a_edge10_state", st_a, 2);
    chk("a_edge10_outs", outs_a(), 32'b00100);
    step(5);
    chk("a_edge15_state", st_a, 3);
    chk("a_edge15_outs", outs_a(), 32'b01100);
    step(4);
    chk("a_edge19_cr", cr_a, 1);
    step(1);
    chk("a_edge20_state", st_a, 4);
    chk("a_edge20_outs", outs_a(), 32'b01000);
    step(4);
    chk("a_edge24_state", st_a, 4);
    step(1);
    chk("a_edge25_state", st_a, 5);
    chk("a_edge25_outs", outs_a(), 32'b01011);
    step(10);
    chk("a_run_hold", st_a, 5);

    er_a = 1;
    step(7);
    er_a = 0;
    step(1);
    chk("a_err7_state", st_a, 5);
    chk("a_err7_rc", rc_a, 0);

    er_a = 1;
    step(7);
    chk("a_err_pre", st_a, 5);
    step(1);
    er_a = 0;
    chk("a_err8_state", st_a, 0);
    chk("a_err8_outs", outs_a(), 32'b00100);
    chk("a_err8_rc", rc_a, 1);
    step(24);
    chk("a_rerun_24", st_a, 4);
    step(1);
    chk("a_rerun_25", st_a, 5);

    rs_a = 1;
    step(1);
    rs_a = 0;
    chk("a_rs_run_state", st_a, 0);
    chk("a_rs_run_rc", rc_a, 2);
    step(17);
    chk("a_pre_rs_state", st_a, 3);
    rs_a = 1;
    step(1);
    rs_a = 0;
    chk("a_rs_len_state", st_a, 0);
    chk("a_rs_len_outs", outs_a(), 32'b00100);
    chk("a_rs_len_rc", rc_a, 3);
    step(24);
    chk("a_rs_len_24", st_a, 4);
    step(1);
    chk("a_rs_len_25", st_a, 5);

    rs_a = 1;
    step(5);
    chk("a_held_state", st_a, 0);
    chk("a_held_rc", rc_a, 4);
    rs_a = 0;
    step(5);
    chk("a_held_rel", st_a, 1);
    step(17);
    chk("a_chiprun", st_a, 4);
    #2;
    rst_a = 1;
    #1;
    chk("a_async_state", st_a, 0);
    chk("a_async_outs", outs_a(), 32'b00100);
    chk("a_async_rc", rc_a, 0);

    @(negedge clk);
    rst_b = 0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk($sformatf("b_d0_edge%0d", k), st_b, 32'(k));
    end
    chk("b_d0_done", dn_b, 1);
    step(3);
    chk("b_d0_hold", st_b, 5);

    er_b = 1;
    step(100);
    chk("b_noauto_state", st_b, 5);
    chk("b_noauto_rc", rc_b, 0);
    er_b = 0;

    for (int k = 1; k <= 5; k++) begin
      rs_b = 1;
      step(1);
      rs_b = 0;
      step(1);
      if (k == 2) chk("b_rc_two", rc_b, 2);
    end
    chk("b_rc_sat", rc_b, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_gateway_link_bringup_seq.md
Name: bsg_gateway_link_bringup_seq

Overview:
Controller that sequences bring-up of one gateway link path: bsg_link_ddr link reset, link enable, chip-side reset release, then node (adapter) enable.
It replaces the ad-hoc counter FSM in the gateway top level with a reusable, restartable, status-reporting block.
It sits in the io clock domain and drives the reset/enable pins of the link, channel tunnel, routers and manycore adapter.
It supports software/pin restart and optional automatic restart on persistent downstream error.

Parameters:
delay_p, 5000, per-step wait; every timed state lasts delay_p+1 cycles; legal range 0..2^counter_width_p-1
counter_width_p, 16, width of the step counter
err_persist_p, 1024, consecutive error_i cycles in RUN that trigger an automatic restart; must be >=1
auto_restart_p, 1, 1 = enable error-triggered restart; 0 = error_i ignored
restart_count_width_p, 8, width of the saturating restart counter

Ports:
clk_i  in  1  io clock (single clock domain)
reset_i  in  1  asynchronous, active-high reset
restart_i  in  1  synchronous request; when sampled high, the next state is INIT
error_i  in  1  downstream error, already synchronous to clk_i
link_reset_o  out  1  to bsg_link_ddr reset_i
link_enable_o  out  1  to bsg_link_ddr link_enable_i
chip_reset_o  out  1  to tunnel/router/link chip_reset_i and adapter reset_i
node_en_o  out  1  to adapter en_i
done_o  out  1  high while in RUN
state_o  out  3  current state encoding
restart_count_o  out  restart_count_width_p  number of restarts taken (restart_i plus automatic), saturating

Behaviour:
- Reset is asynchronous and active-high. On reset: state=INIT, step counter=0, error counter=0, restart_count_o=0.
- Outputs are a Moore decode of the state register, so they change on the same edge as the state.
- Reset/INIT output values: link_reset_o=0, link_enable_o=0, chip_reset_o=1, node_en_o=0, done_o=0.
- States and decoded outputs, written as link_reset/link_enable/chip_reset/node_en/done:
  - INIT (0): 0/0/1/0/0
  - LINK_RST (1): 1/0/1/0/0
  - LINK_WAIT (2): 0/0/1/0/0
  - LINK_EN (3): 0/1/1/0/0
  - CHIP_RUN (4): 0/1/0/0/0
  - RUN (5): 0/1/0/1/1
  - Encodings 6 and 7 are illegal; the FSM goes to INIT on the next cycle.
- Timed states are 0..4. Step counter behaviour:
  - It increments each cycle.
  - When counter==delay_p, the counter clears to 0 and the state advances to state+1.
  - Each timed state therefore lasts exactly delay_p+1 cycles.
  - RUN is terminal; the counter is held at 0 in RUN.
- Reset deassert to RUN takes exactly 5*(delay_p+1) rising edges.
- restart_i:
  - Has priority over counter expiry and over auto-restart.
  - Sampled high in any state: next state=INIT, step counter=0, error counter=0, restart_count_o increments (saturating).
  - Held high: the FSM stays in INIT, and restart_count_o increments once per rising edge of restart_i, not per cycle.
- Auto-restart (auto_restart_p=1):
  - Only in RUN, the error counter increments while error_i=1 and clears on any cycle with error_i=0.
  - When the error counter reaches err_persist_p-1 with error_i=1, the next state is INIT and restart_count_o increments.
  - Outside RUN the error counter is held at 0.
- restart_count_o saturates at all-ones with no wrap.
- delay_p=0: each timed state lasts 1 cycle, so RUN is reached 5 cycles after reset deassert.
- Async reset mid-sequence returns to INIT immediately, with no glitch on chip_reset_o, which is already 1 in INIT.

Decomposition:
- Package bsg_gateway_seq_pkg holds:
  - typedef enum logic [2:0] for bring-up states INIT..RUN;
  - a localparam for the number of timed states (5).
- Sub-module: a step counter instance, bsg_counter_clear_up, with clear driven by expiry/restart and up driven by "state is timed".
- The error persistence counter is inline.

Test Plan:
- delay_p=4, reset deassert, no restart/error:
  - link_reset_o goes high after edge 5 and low after edge 10;
  - link_enable_o goes high after edge 15;
  - chip_reset_o goes low after edge 20;
  - node_en_o=done_o=1 after edge 25; state_o=5 thereafter.
- delay_p=0: state_o steps 0,1,2,3,4,5 on consecutive edges; done_o=1 after edge 5.
- delay_p=4: assert restart_i for one cycle in LINK_EN (state 3) → next edge state_o=0, chip_reset_o=1, link_enable_o=0, restart_count_o=1; RUN is reached 25 edges later.
- auto_restart_p=1, err_persist_p=8, in RUN:
  - error_i high 7 cycles, then low → stays in RUN;
  - error_i high 8 consecutive cycles → state_o=0 on the next edge, restart_count_o increments.
- auto_restart_p=0: error_i held high 100 cycles in RUN → stays in RUN, restart_count_o unchanged.
- restart_count_width_p=2: 5 separate restart_i pulses → restart_count_o=3 (saturated).
- Assert reset_i asynchronously mid-CHIP_RUN → state_o=0 and outputs at reset values without waiting for a clock edge.
